// File: rtl/iob_bus_split.sv
// iob_bus_split: routes one CPU IOb request port to 2**SEL_W slaves using an
// address select field, and steers the selected slave's response back.
// Reads are tracked one at a time; a read that never returns is terminated by
// a timeout that delivers zero data and raises a sticky err flag.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | request passed to the addressed slave, ready from that slave
//   ST_RD_PEND | read accepted, waiting for rvalid from pend_sel or timeout
module iob_bus_split #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 1,
  parameter int SEL_MSB   = ADDR_W - 2,
  parameter int TIMEOUT_W = 8,
  localparam int STRB_W   = DATA_W / 8,
  localparam int N_SLAVES = 2 ** SEL_W,
  localparam int REQ_W    = 1 + ADDR_W + DATA_W + STRB_W,
  localparam int RESP_W   = DATA_W + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_W-1:0]             m_req,
  output logic [RESP_W-1:0]            m_resp,
  output logic [N_SLAVES*REQ_W-1:0]    s_req,
  input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
  output logic                         err,
  input  logic                         err_clr
);

  // address field starts just above wdata and wstrb in the request word
  localparam int ADDR_LSB = DATA_W + STRB_W;
  localparam logic [TIMEOUT_W-1:0] TIMER_MAX = '1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_PEND = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      pend_sel_q, pend_sel_d;
  logic [TIMEOUT_W-1:0]  timer_q, timer_d;
  logic                  err_q, err_d;

  logic                  m_avalid;
  logic [STRB_W-1:0]     m_wstrb;
  logic [SEL_W-1:0]      sel;

  logic [DATA_W-1:0]     s_rdata [N_SLAVES];
  logic [N_SLAVES-1:0]   s_rvalid;
  logic [N_SLAVES-1:0]   s_ready;

  logic [DATA_W-1:0]     m_rdata;
  logic                  m_rvalid;
  logic                  m_ready;

  assign m_avalid = m_req[REQ_W-1];
  assign m_wstrb  = m_req[STRB_W-1:0];
  assign sel      = m_req[ADDR_LSB + SEL_MSB -: SEL_W];

  // unpack each slave's response slice into per-slave fields
  for (genvar k = 0; k < N_SLAVES; k++) begin : g_unpack
    assign s_rdata[k]  = s_resp[k*RESP_W + 2 +: DATA_W];
    assign s_rvalid[k] = s_resp[k*RESP_W + 1];
    assign s_ready[k]  = s_resp[k*RESP_W];
  end

  // next-state, request routing and response steering
  always_comb begin
    state_d    = state_q;
    pend_sel_d = pend_sel_q;
    timer_d    = timer_q;
    err_d      = err_q;
    s_req      = '0;
    m_ready    = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = '0;

    // a timeout in the same cycle overrides the clear below
    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        s_req[int'(sel)*REQ_W +: REQ_W] = m_req;
        m_ready = s_ready[sel];
        // a zero wstrb marks a read; writes complete without a response
        if (m_avalid && s_ready[sel] && (m_wstrb == '0)) begin
          pend_sel_d = sel;
          timer_d    = '0;
          state_d    = ST_RD_PEND;
        end
      end

      ST_RD_PEND: begin
        m_rdata  = s_rdata[pend_sel_q];
        m_rvalid = s_rvalid[pend_sel_q];
        if (s_rvalid[pend_sel_q]) begin
          // slave data wins even on the terminal timer cycle
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_MAX) begin
          m_rvalid = 1'b1;
          m_rdata  = '0;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_sel_q <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_sel_q <= pend_sel_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
    end
  end

  assign m_resp = {m_rdata, m_rvalid, m_ready};
  assign err    = err_q;

endmodule

// File: tb/tb_iob_bus_split.sv
// Testbench for iob_bus_split: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_iob_bus_split;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int RESP_W = DATA_W + 2;
  localparam int TMAX   = 255;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [REQ_W-1:0]      m_req;
  logic [RESP_W-1:0]     m_resp;
  logic [2*REQ_W-1:0]    s_req;
  logic [2*RESP_W-1:0]   s_resp;
  logic                  err;
  logic                  err_clr;

  logic                  drv_avalid;
  logic [ADDR_W-1:0]     drv_addr;
  logic [DATA_W-1:0]     drv_wdata;
  logic [STRB_W-1:0]     drv_wstrb;
  logic [DATA_W-1:0]     sl_rdata  [2];
  logic                  sl_rvalid [2];
  logic                  sl_ready  [2];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  // reference model: one outstanding read, counted in whole wait cycles
  bit mdl_pend = 0;
  int mdl_sel  = 0;
  int mdl_wait = 0;
  bit mdl_err  = 0;

  assign m_req  = {drv_avalid, drv_addr, drv_wdata, drv_wstrb};
  assign s_resp = {sl_rdata[1], sl_rvalid[1], sl_ready[1],
                   sl_rdata[0], sl_rvalid[0], sl_ready[0]};

  iob_bus_split #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(1), .SEL_MSB(30), .TIMEOUT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp),
    .s_req(s_req), .s_resp(s_resp), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int sel_of(input logic [31:0] a);
    return int'((a >> 30) & 32'h1);
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int s;
    logic [RESP_W-1:0]  e_resp;
    logic [2*REQ_W-1:0] e_sreq;
    s = sel_of(drv_addr);
    e_sreq = '0;
    if (!mdl_pend) begin
      e_sreq[s*REQ_W +: REQ_W] = m_req;
      e_resp = {32'h0, 1'b0, sl_ready[s]};
    end else if (sl_rvalid[mdl_sel]) begin
      e_resp = {sl_rdata[mdl_sel], 1'b1, 1'b0};
    end else if (mdl_wait == TMAX) begin
      e_resp = {32'h0, 1'b1, 1'b0};
    end else begin
      e_resp = {sl_rdata[mdl_sel], 1'b0, 1'b0};
    end
    check("cyc_resp", m_resp, e_resp);
    check("cyc_sreq", s_req, e_sreq);
    check("cyc_err", err, mdl_err);
  endtask

  task automatic model_edge();
    int s;
    bit timeout;
    s = sel_of(drv_addr);
    timeout = 0;
    if (rst) begin
      mdl_pend = 0; mdl_sel = 0; mdl_wait = 0; mdl_err = 0;
      return;
    end
    if (!mdl_pend) begin
      if (drv_avalid && sl_ready[s] && drv_wstrb == 0) begin
        mdl_pend = 1; mdl_sel = s; mdl_wait = 0;
      end
    end else if (sl_rvalid[mdl_sel]) begin
      mdl_pend = 0;
    end else if (mdl_wait == TMAX) begin
      mdl_pend = 0; timeout = 1;
    end else begin
      mdl_wait++;
    end
    if (timeout) mdl_err = 1;
    else if (err_clr) mdl_err = 0;
  endtask

  task automatic at_neg();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_req(input logic av, input logic [31:0] a, input logic [3:0] ws);
    drv_avalid = av; drv_addr = a; drv_wdata = 32'hA5A5_0000 | a; drv_wstrb = ws;
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    set_req(1'b1, 32'h4000_0000, 4'h0);
    for (int k = 0; k < 2; k++) begin
      sl_rdata[k] = 32'h0; sl_rvalid[k] = 1'b0; sl_ready[k] = 1'b0;
    end
    sl_rvalid[1] = 1'b1; sl_rdata[1] = 32'h1111_2222;
    #3;
    check_outputs();
    check("rst_resp_zero", m_resp, 34'h0);
    check("rst_err_zero", err, 1'b0);
    at_pos();
    rst = 1'b0; sl_rvalid[1] = 1'b0;

    // write to slave0
    set_req(1'b1, 32'h0000_0010, 4'hF);
    sl_ready[0] = 1'b1; sl_ready[1] = 1'b0;
    at_neg();
    check("w036_s0_avalid", s_req[REQ_W-1], 1'b1);
    check("w036_s1_zero", s_req[2*REQ_W-1:REQ_W], '0);
    check("w036_ready", m_resp[0], 1'b1);
    check("w036_rvalid", m_resp[1], 1'b0);
    at_pos();
    drv_avalid = 1'b0;
    at_neg();
    check("w036_still_idle", m_resp[0], 1'b1);
    at_pos();

    // read from slave1, data three cycles after accept
    set_req(1'b1, 32'h4000_0004, 4'h0);
    sl_ready[1] = 1'b1;
    at_neg();
    check("r037_s1_fwd", s_req[2*REQ_W-1:REQ_W], m_req);
    at_pos();
    drv_avalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin sl_rvalid[1] = 1'b1; sl_rdata[1] = 32'h1234_5678; end
      at_neg();
      if (i < 2) check("r037_wait", m_resp[1:0], 2'b00);
      else check("r037_data", m_resp, {32'h1234_5678, 2'b10});
      at_pos();
    end
    sl_rvalid[1] = 1'b0;
    at_neg();
    check("r037_back_idle", m_resp[1:0], 2'b01);
    at_pos();

    // foreign rvalid while reading slave1
    set_req(1'b1, 32'h4000_0008, 4'h0);
    at_neg(); at_pos();
    drv_avalid = 1'b0;
    sl_rvalid[0] = 1'b1; sl_rdata[0] = 32'hDEAD_BEEF;
    at_neg();
    check("r038_s0_ignored", m_resp[1], 1'b0);
    at_pos();
    sl_rvalid[0] = 1'b0; sl_rvalid[1] = 1'b1; sl_rdata[1] = 32'hCAFE_F00D;
    at_neg();
    check("r038_s1_data", m_resp, {32'hCAFE_F00D, 2'b10});
    at_pos();
    sl_rvalid[1] = 1'b0;

    // timeout on slave0
    set_req(1'b1, 32'h0000_0020, 4'h0);
    sl_rdata[0] = 32'h55AA_55AA;
    at_neg(); at_pos();
    drv_avalid = 1'b0;
    for (int i = 0; i <= TMAX; i++) begin
      at_neg();
      if (i == TMAX) check("r039_timeout", m_resp, {32'h0, 2'b10});
      else if (i == TMAX - 1) check("r039_pre_timeout", m_resp[1], 1'b0);
      at_pos();
    end
    sl_rvalid[0] = 1'b1;
    at_neg();
    check("r039_err_set", err, 1'b1);
    check("r039_late_ignored", m_resp[1], 1'b0);
    at_pos();
    sl_rvalid[0] = 1'b0;

    // second timeout with err_clr held: clear then re-set on terminal cycle
    set_req(1'b1, 32'h0000_0030, 4'h0);
    at_neg(); at_pos();
    drv_avalid = 1'b0; err_clr = 1'b1;
    for (int i = 0; i <= TMAX; i++) begin
      at_neg();
      if (i == 1) check("r031_cleared", err, 1'b0);
      at_pos();
    end
    at_neg();
    check("r031_timeout_wins", err, 1'b1);
    at_pos();
    err_clr = 1'b0;

    // asynchronous reset mid-read
    set_req(1'b1, 32'h4000_0010, 4'h0);
    at_neg(); at_pos();
    drv_avalid = 1'b0;
    at_neg();
    check("r041_pending", m_resp[0], 1'b0);
    at_pos();
    #2;
    rst = 1'b1;
    mdl_pend = 0; mdl_sel = 0; mdl_wait = 0; mdl_err = 0;
    #1;
    check("r041_err_async", err, 1'b0);
    check("r041_idle_async", m_resp, 34'h1);
    check_outputs();
    at_pos();
    rst = 1'b0;
    sl_rvalid[1] = 1'b1; sl_rdata[1] = 32'h0000_0077;
    at_neg();
    check("r041_late_ignored", m_resp[1], 1'b0);
    at_pos();
    sl_rvalid[1] = 1'b0;
    set_req(1'b1, 32'h4000_0100, 4'h3);
    at_neg();
    check("r041_write_s1", s_req[2*REQ_W-1:REQ_W], m_req);
    check("r041_write_s0_zero", s_req[REQ_W-1:0], '0);
    at_pos();

    // rvalid exactly on the terminal timer cycle
    set_req(1'b1, 32'h4000_0020, 4'h0);
    sl_rdata[1] = 32'h0BAD_BEEF;
    at_neg(); at_pos();
    drv_avalid = 1'b0;
    for (int i = 0; i <= TMAX; i++) begin
      if (i == TMAX) sl_rvalid[1] = 1'b1;
      at_neg();
      if (i == TMAX) check("r040_data", m_resp, {32'h0BAD_BEEF, 2'b10});
      at_pos();
    end
    sl_rvalid[1] = 1'b0;
    at_neg();
    check("r040_no_err", err, 1'b0);
    at_pos();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      drv_avalid = ($urandom_range(0, 1) == 1);
      drv_addr   = $urandom;
      drv_wdata  = $urandom;
      drv_wstrb  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++) begin
        sl_ready[k]  = ($urandom_range(0, 3) != 0);
        sl_rvalid[k] = ($urandom_range(0, 3) == 0);
        sl_rdata[k]  = $urandom;
      end
      err_clr = ($urandom_range(0, 19) == 0);
      at_neg();
      at_pos();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
